// File: rtl/bsg_axil_fifo_master.sv
// AXI4-Lite master engine: buffers read/write commands in a small FIFO,
// runs one AXI-Lite transaction at a time and hands back one response per
// command. A slave that never answers is cut off after timeout_p cycles; any
// late B/R is then swallowed in DRAIN so it cannot be mistaken for the answer
// to the next command.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | no transaction; pops the queue head when a command waits
// WR_ISSUE  | awvalid/wvalid up, each drops on its own handshake
// WR_WAIT_B | bready up, waiting for the write response
// RD_ISSUE  | arvalid up, waiting for arready
// RD_WAIT_R | rready up, waiting for read data
// RESP      | resp_v_o up, held until resp_yumi_i
// DRAIN     | after a timeout: drop stale valids, discard one late B/R
module bsg_axil_fifo_master #(
    parameter int addr_width_p = 32,
    parameter int data_width_p = 32,
    parameter int cmd_els_p    = 4,
    parameter int timeout_p    = 1024
) (
    input  logic                      aclk_i,
    input  logic                      aresetn_i,

    input  logic                      cmd_v_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_we_i,
    input  logic [addr_width_p-1:0]   cmd_addr_i,
    input  logic [data_width_p-1:0]   cmd_data_i,
    input  logic [data_width_p/8-1:0] cmd_strb_i,

    output logic                      resp_v_o,
    input  logic                      resp_yumi_i,
    output logic                      resp_we_o,
    output logic [data_width_p-1:0]   resp_data_o,
    output logic [1:0]                resp_code_o,
    output logic                      resp_timeout_o,

    output logic                      error_o,
    output logic                      busy_o,

    output logic [addr_width_p-1:0]   m_axil_awaddr,
    output logic [2:0]                m_axil_awprot,
    output logic                      m_axil_awvalid,
    input  logic                      m_axil_awready,

    output logic [data_width_p-1:0]   m_axil_wdata,
    output logic [data_width_p/8-1:0] m_axil_wstrb,
    output logic                      m_axil_wvalid,
    input  logic                      m_axil_wready,

    input  logic [1:0]                m_axil_bresp,
    input  logic                      m_axil_bvalid,
    output logic                      m_axil_bready,

    output logic [addr_width_p-1:0]   m_axil_araddr,
    output logic [2:0]                m_axil_arprot,
    output logic                      m_axil_arvalid,
    input  logic                      m_axil_arready,

    input  logic [data_width_p-1:0]   m_axil_rdata,
    input  logic [1:0]                m_axil_rresp,
    input  logic                      m_axil_rvalid,
    output logic                      m_axil_rready
);

    localparam int strb_width_lp  = data_width_p / 8;
    localparam int entry_width_lp = 1 + addr_width_p + data_width_p + strb_width_lp;
    localparam int ptr_width_lp   = (cmd_els_p > 1) ? $clog2(cmd_els_p) : 1;
    localparam int cnt_width_lp   = $clog2(cmd_els_p + 1);
    localparam int tmr_width_lp   = (timeout_p > 1) ? $clog2(timeout_p + 1) : 1;
    // The timeout fires on the timeout_p-th cycle spent in ISSUE/WAIT.
    localparam logic [tmr_width_lp-1:0] tmr_last_lp =
        (timeout_p > 0) ? tmr_width_lp'(timeout_p - 1) : '0;

    typedef enum logic [2:0] {
        IDLE, WR_ISSUE, WR_WAIT_B, RD_ISSUE, RD_WAIT_R, RESP, DRAIN
    } state_t;

    state_t state_q, state_n;

    // ---------------- command queue ----------------
    logic [entry_width_lp-1:0] mem_r [cmd_els_p];
    logic [ptr_width_lp-1:0]   wr_ptr_r, rd_ptr_r;
    logic [cnt_width_lp-1:0]   count_r;
    logic                      ready_en_r;
    logic                      full, empty, enq, deq;

    logic                      head_we;
    logic [addr_width_p-1:0]   head_addr;
    logic [data_width_p-1:0]   head_data;
    logic [strb_width_lp-1:0]  head_strb;

    assign full        = (count_r == cnt_width_lp'(cmd_els_p));
    assign empty       = (count_r == '0);
    assign cmd_ready_o = ready_en_r & (~full | deq);
    assign enq         = cmd_v_i & cmd_ready_o;
    assign {head_we, head_addr, head_data, head_strb} = mem_r[rd_ptr_r];

    function automatic logic [ptr_width_lp-1:0] ptr_inc(input logic [ptr_width_lp-1:0] p);
        return (p == ptr_width_lp'(cmd_els_p - 1)) ? '0 : p + ptr_width_lp'(1);
    endfunction

    // Queue storage; contents need no reset, the pointers define validity.
    always_ff @(posedge aclk_i) begin
        if (enq) mem_r[wr_ptr_r] <= {cmd_we_i, cmd_addr_i, cmd_data_i, cmd_strb_i};
    end

    // Queue pointers and occupancy; ready_en holds cmd_ready_o low for the
    // first cycle out of reset.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            ready_en_r <= 1'b0;
        end else begin
            ready_en_r <= 1'b1;
            if (enq) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (deq) rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({enq, deq})
                2'b10:   count_r <= count_r + cnt_width_lp'(1);
                2'b01:   count_r <= count_r - cnt_width_lp'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // ---------------- transaction engine ----------------
    logic                      cur_we_q;
    logic [addr_width_p-1:0]   cur_addr_q;
    logic [data_width_p-1:0]   cur_data_q;
    logic [strb_width_lp-1:0]  cur_strb_q;

    logic awvalid_q, awvalid_n, wvalid_q, wvalid_n, arvalid_q, arvalid_n;
    logic addr_acc_q, addr_acc_n;   // AW or AR handshake seen for current command
    logic timed_out_q, timed_out_n;
    logic [tmr_width_lp-1:0] tmr_q, tmr_n;
    logic                    resp_we_q, resp_we_n;
    logic [data_width_p-1:0] resp_data_q, resp_data_n;
    logic [1:0]              resp_code_q, resp_code_n;
    logic                    resp_timeout_q, resp_timeout_n;
    logic                    error_q, error_n;
    logic                    bready_c, rready_c;

    logic aw_hs, w_hs, ar_hs, timeout_hit, drain_acc;

    assign aw_hs       = awvalid_q & m_axil_awready;
    assign w_hs        = wvalid_q & m_axil_wready;
    assign ar_hs       = arvalid_q & m_axil_arready;
    assign timeout_hit = (timeout_p != 0) && (tmr_q == tmr_last_lp);
    assign drain_acc   = addr_acc_q | aw_hs | ar_hs;

    // State register and all registered engine outputs.
    always_ff @(posedge aclk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state_q        <= IDLE;
            awvalid_q      <= 1'b0;
            wvalid_q       <= 1'b0;
            arvalid_q      <= 1'b0;
            addr_acc_q     <= 1'b0;
            timed_out_q    <= 1'b0;
            tmr_q          <= '0;
            resp_we_q      <= 1'b0;
            resp_data_q    <= '0;
            resp_code_q    <= 2'b00;
            resp_timeout_q <= 1'b0;
            error_q        <= 1'b0;
            cur_we_q       <= 1'b0;
            cur_addr_q     <= '0;
            cur_data_q     <= '0;
            cur_strb_q     <= '0;
        end else begin
            state_q        <= state_n;
            awvalid_q      <= awvalid_n;
            wvalid_q       <= wvalid_n;
            arvalid_q      <= arvalid_n;
            addr_acc_q     <= addr_acc_n;
            timed_out_q    <= timed_out_n;
            tmr_q          <= tmr_n;
            resp_we_q      <= resp_we_n;
            resp_data_q    <= resp_data_n;
            resp_code_q    <= resp_code_n;
            resp_timeout_q <= resp_timeout_n;
            error_q        <= error_n;
            if (deq) begin
                cur_we_q   <= head_we;
                cur_addr_q <= head_addr;
                cur_data_q <= head_data;
                cur_strb_q <= head_strb;
            end
        end
    end

    // Next-state, handshake tracking, timeout and response capture.
    always_comb begin
        state_n        = state_q;
        awvalid_n      = awvalid_q;
        wvalid_n       = wvalid_q;
        arvalid_n      = arvalid_q;
        addr_acc_n     = addr_acc_q;
        timed_out_n    = timed_out_q;
        tmr_n          = tmr_q;
        resp_we_n      = resp_we_q;
        resp_data_n    = resp_data_q;
        resp_code_n    = resp_code_q;
        resp_timeout_n = resp_timeout_q;
        error_n        = error_q;
        deq            = 1'b0;
        bready_c       = 1'b0;
        rready_c       = 1'b0;

        // Address/data handshakes are tracked in every state where a valid
        // may still be up, including RESP after a timeout.
        if (aw_hs) begin
            awvalid_n  = 1'b0;
            addr_acc_n = 1'b1;
        end
        if (w_hs) wvalid_n = 1'b0;
        if (ar_hs) begin
            arvalid_n  = 1'b0;
            addr_acc_n = 1'b1;
        end

        if (state_q == WR_ISSUE || state_q == WR_WAIT_B ||
            state_q == RD_ISSUE || state_q == RD_WAIT_R) begin
            tmr_n = tmr_q + tmr_width_lp'(1);
        end

        case (state_q)
            IDLE: begin
                if (!empty) begin
                    deq         = 1'b1;
                    tmr_n       = '0;
                    addr_acc_n  = 1'b0;
                    timed_out_n = 1'b0;
                    if (head_we) begin
                        state_n   = WR_ISSUE;
                        awvalid_n = 1'b1;
                        wvalid_n  = 1'b1;
                    end else begin
                        state_n   = RD_ISSUE;
                        arvalid_n = 1'b1;
                    end
                end
            end
            WR_ISSUE: begin
                if (timeout_hit) begin
                    state_n = RESP;
                end else if ((~awvalid_q | aw_hs) & (~wvalid_q | w_hs)) begin
                    state_n = WR_WAIT_B;
                end
            end
            WR_WAIT_B: begin
                bready_c = 1'b1;
                if (m_axil_bvalid) begin
                    state_n        = RESP;
                    resp_we_n      = 1'b1;
                    resp_data_n    = '0;
                    resp_code_n    = m_axil_bresp;
                    resp_timeout_n = 1'b0;
                    if (m_axil_bresp != 2'b00) error_n = 1'b1;
                end else if (timeout_hit) begin
                    state_n = RESP;
                end
            end
            RD_ISSUE: begin
                if (timeout_hit) begin
                    state_n = RESP;
                end else if (ar_hs) begin
                    state_n = RD_WAIT_R;
                end
            end
            RD_WAIT_R: begin
                rready_c = 1'b1;
                if (m_axil_rvalid) begin
                    state_n        = RESP;
                    resp_we_n      = 1'b0;
                    resp_data_n    = m_axil_rdata;
                    resp_code_n    = m_axil_rresp;
                    resp_timeout_n = 1'b0;
                    if (m_axil_rresp != 2'b00) error_n = 1'b1;
                end else if (timeout_hit) begin
                    state_n = RESP;
                end
            end
            RESP: begin
                if (resp_yumi_i) state_n = timed_out_q ? DRAIN : IDLE;
            end
            DRAIN: begin
                // Valids drop now; a handshake on this cycle still counts,
                // so drain_acc includes the live handshakes.
                awvalid_n = 1'b0;
                wvalid_n  = 1'b0;
                arvalid_n = 1'b0;
                if (cur_we_q) bready_c = drain_acc;
                else          rready_c = drain_acc;
                if (!drain_acc) begin
                    state_n = IDLE;
                end else if (cur_we_q ? m_axil_bvalid : m_axil_rvalid) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        // Timeout response; only reached when no B/R completed this cycle.
        if (state_n == RESP && state_q != RESP && timeout_hit &&
            !(state_q == WR_WAIT_B && m_axil_bvalid) &&
            !(state_q == RD_WAIT_R && m_axil_rvalid)) begin
            resp_we_n      = cur_we_q;
            resp_data_n    = '0;
            resp_code_n    = 2'b10;
            resp_timeout_n = 1'b1;
            timed_out_n    = 1'b1;
            error_n        = 1'b1;
        end
    end

    assign m_axil_awaddr  = cur_addr_q;
    assign m_axil_awprot  = 3'b000;
    assign m_axil_awvalid = awvalid_q;
    assign m_axil_wdata   = cur_data_q;
    assign m_axil_wstrb   = cur_strb_q;
    assign m_axil_wvalid  = wvalid_q;
    assign m_axil_bready  = bready_c;
    assign m_axil_araddr  = cur_addr_q;
    assign m_axil_arprot  = 3'b000;
    assign m_axil_arvalid = arvalid_q;
    assign m_axil_rready  = rready_c;

    assign resp_v_o       = (state_q == RESP);
    assign resp_we_o      = resp_we_q;
    assign resp_data_o    = resp_data_q;
    assign resp_code_o    = resp_code_q;
    assign resp_timeout_o = resp_timeout_q;
    assign error_o        = error_q;
    assign busy_o         = ~empty | (state_q != IDLE);

endmodule

// File: tb/tb_bsg_axil_fifo_master.sv
// Directed bench for bsg_axil_fifo_master: the bench plays the AXI-Lite slave
// and the command/response host from one linear initial block.
module tb_bsg_axil_fifo_master;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        cmd_v = 1'b0, cmd_ready, cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_data = '0;
    logic [3:0]  cmd_strb = '0;
    logic        resp_v, resp_yumi = 1'b0, resp_we, resp_timeout, error, busy;
    logic [31:0] resp_data;
    logic [1:0]  resp_code;
    logic [31:0] awaddr, wdata, araddr, rdata = '0;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
    logic [1:0]  bresp = '0, rresp = '0;
    logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
    logic        rvalid = 1'b0, rready;

    int checks = 0;
    int errors = 0;
    int aw_cnt = 0;
    int w_cnt  = 0;

    bsg_axil_fifo_master #(
        .addr_width_p(32), .data_width_p(32), .cmd_els_p(4), .timeout_p(16)
    ) dut (
        .aclk_i(clk), .aresetn_i(aresetn),
        .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_data_i(cmd_data), .cmd_strb_i(cmd_strb),
        .resp_v_o(resp_v), .resp_yumi_i(resp_yumi), .resp_we_o(resp_we),
        .resp_data_o(resp_data), .resp_code_o(resp_code),
        .resp_timeout_o(resp_timeout), .error_o(error), .busy_o(busy),
        .m_axil_awaddr(awaddr), .m_axil_awprot(awprot),
        .m_axil_awvalid(awvalid), .m_axil_awready(awready),
        .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
        .m_axil_wvalid(wvalid), .m_axil_wready(wready),
        .m_axil_bresp(bresp), .m_axil_bvalid(bvalid), .m_axil_bready(bready),
        .m_axil_araddr(araddr), .m_axil_arprot(arprot),
        .m_axil_arvalid(arvalid), .m_axil_arready(arready),
        .m_axil_rdata(rdata), .m_axil_rresp(rresp),
        .m_axil_rvalid(rvalid), .m_axil_rready(rready)
    );

    always #5 clk = ~clk;

    // Handshake counters used to prove each channel fires exactly once.
    always @(posedge clk) begin
        if (awvalid && awready) aw_cnt++;
        if (wvalid && wready)   w_cnt++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic we, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        int n = 0;
        cmd_v = 1'b1; cmd_we = we; cmd_addr = a; cmd_data = d; cmd_strb = s;
        while (!cmd_ready && n < 40) begin tick(); n++; end
        chk("push_ready", n < 40, 1'b1);
        tick();
        cmd_v = 1'b0;
    endtask

    task automatic wait_issue();
        int n = 0;
        while (!(awvalid || arvalid) && n < 40) begin tick(); n++; end
        chk("issue_seen", n < 40, 1'b1);
    endtask

    // Answer the outstanding transaction with the given resp code / read data.
    task automatic serve(input logic [1:0] code, input logic [31:0] rd);
        int n = 0;
        while (!(bready || rready) && n < 40) begin tick(); n++; end
        chk("serve_ready", n < 40, 1'b1);
        if (bready) begin
            bvalid = 1'b1; bresp = code;
        end else begin
            rvalid = 1'b1; rresp = code; rdata = rd;
        end
        tick();
        bvalid = 1'b0; rvalid = 1'b0;
    endtask

    task automatic get_resp(output logic we, output logic [31:0] d,
                            output logic [1:0] c, output logic to);
        int n = 0;
        while (!resp_v && n < 40) begin tick(); n++; end
        chk("resp_seen", n < 40, 1'b1);
        we = resp_we; d = resp_data; c = resp_code; to = resp_timeout;
        resp_yumi = 1'b1;
        tick();
        resp_yumi = 1'b0;
    endtask

    logic        r_we, r_to;
    logic [31:0] r_d;
    logic [1:0]  r_c;
    int          acc, a0, w0, n;

    initial begin
        // ---- reset ----
        tick(); tick(); tick();
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        chk("rst_resp_v", resp_v, 1'b0);
        chk("rst_valids", {awvalid, wvalid, arvalid, bready, rready}, 5'b0);
        chk("rst_error", error, 1'b0);
        chk("rst_busy", busy, 1'b0);
        aresetn = 1'b1;
        chk("rst_ready_late", cmd_ready, 1'b0);
        tick();
        chk("rst_ready_up", cmd_ready, 1'b1);

        // ---- 1: simple write, B two cycles after bready ----
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        push(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF);
        wait_issue();
        chk("t1_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("t1_awaddr", awaddr, 32'h10);
        chk("t1_wdata", wdata, 32'hDEAD_BEEF);
        chk("t1_wstrb", wstrb, 4'hF);
        chk("t1_prot", {awprot, arprot}, 6'b0);
        tick();
        chk("t1_bready", bready, 1'b1);
        tick(); tick();
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        chk("t1_resp_v", resp_v, 1'b1);
        chk("t1_resp", {resp_we, resp_code, resp_timeout, resp_data}, {1'b1, 2'b00, 1'b0, 32'h0});
        chk("t1_error", error, 1'b0);
        tick();
        chk("t1_hold", {resp_v, resp_we, resp_code}, {1'b1, 1'b1, 2'b00});
        resp_yumi = 1'b1; tick(); resp_yumi = 1'b0;
        chk("t1_resp_done", resp_v, 1'b0);
        chk("t1_idle", busy, 1'b0);

        // ---- 2: W accepted three cycles before AW ----
        awready = 1'b0;
        a0 = aw_cnt; w0 = w_cnt;
        push(1'b1, 32'h14, 32'hA5A5_A5A5, 4'h3);
        wait_issue();
        tick();
        chk("t2_w_dropped", {wvalid, awvalid, bready}, 3'b010);
        tick(); tick();
        chk("t2_aw_hold", {awvalid, bready}, 2'b10);
        chk("t2_awaddr", awaddr, 32'h14);
        awready = 1'b1;
        tick();
        chk("t2_wait_b", {awvalid, wvalid, bready}, 3'b001);
        chk("t2_aw_once", aw_cnt - a0, 1);
        chk("t2_w_once", w_cnt - w0, 1);
        serve(2'b00, 32'h0);
        get_resp(r_we, r_d, r_c, r_to);
        chk("t2_resp", {r_we, r_c, r_to}, {1'b1, 2'b00, 1'b0});

        // ---- 3: read with SLVERR, error_o sticky ----
        push(1'b0, 32'h20, 32'h0, 4'h0);
        wait_issue();
        chk("t3_araddr", {arvalid, araddr}, {1'b1, 32'h20});
        serve(2'b10, 32'h1234_5678);
        get_resp(r_we, r_d, r_c, r_to);
        chk("t3_rdata", r_d, 32'h1234_5678);
        chk("t3_resp", {r_we, r_c, r_to}, {1'b0, 2'b10, 1'b0});
        chk("t3_error_set", error, 1'b1);
        push(1'b1, 32'h24, 32'h1, 4'h1);
        serve(2'b00, 32'h0);
        get_resp(r_we, r_d, r_c, r_to);
        chk("t3_okay_after", r_c, 2'b00);
        chk("t3_error_sticky", error, 1'b1);

        // ---- 4: six commands against a stalled slave ----
        // One command sits in the engine, four fill the queue: five accepted.
        awready = 1'b0; wready = 1'b0; arready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_v = 1'b1; cmd_we = (i % 2 == 0); cmd_addr = 32'h100 + 4 * i;
            cmd_data = 32'hA000_0000 + i; cmd_strb = 4'hF;
            if (!cmd_ready) break;
            tick();
            acc++;
        end
        cmd_v = 1'b0;
        chk("t4_accepted", acc, 5);
        chk("t4_full", cmd_ready, 1'b0);
        chk("t4_busy", busy, 1'b1);
        awready = 1'b1; wready = 1'b1; arready = 1'b1;
        serve(2'b00, 32'h0);
        get_resp(r_we, r_d, r_c, r_to);
        chk("t4_resp0", {r_we, r_c, r_to, r_d}, {1'b1, 2'b00, 1'b0, 32'h0});
        push(1'b0, 32'h114, 32'hA000_0005, 4'hF);
        for (int i = 1; i < 6; i++) begin
            serve(2'b00, 32'hC0DE_0000 + i);
            get_resp(r_we, r_d, r_c, r_to);
            chk("t4_order_we", r_we, (i % 2 == 0));
            chk("t4_order_data", r_d, (i % 2 == 0) ? 32'h0 : 32'hC0DE_0000 + i);
            chk("t4_order_code", {r_c, r_to}, 3'b000);
        end
        tick();
        chk("t4_done_busy", busy, 1'b0);

        // ---- 5: read timeout, late R drained ----
        push(1'b0, 32'h40, 32'h0, 4'h0);
        wait_issue();
        n = 0;
        while (!resp_v && n < 40) begin tick(); n++; end
        chk("t5_timeout_cycle", n, 16);
        chk("t5_resp", {resp_we, resp_code, resp_timeout, resp_data}, {1'b0, 2'b10, 1'b1, 32'h0});
        chk("t5_error", error, 1'b1);
        resp_yumi = 1'b1; tick(); resp_yumi = 1'b0; n++;
        chk("t5_drain", {rready, resp_v, busy}, 3'b101);
        while (n < 29) begin tick(); n++; end
        rvalid = 1'b1; rdata = 32'hBAD0_BAD0; rresp = 2'b00;
        tick();
        rvalid = 1'b0;
        chk("t5_drained", {rready, busy}, 2'b00);
        tick(); tick(); tick();
        chk("t5_no_second", resp_v, 1'b0);
        push(1'b0, 32'h44, 32'h0, 4'h0);
        serve(2'b00, 32'h55AA_55AA);
        get_resp(r_we, r_d, r_c, r_to);
        chk("t5_next", {r_we, r_c, r_to, r_d}, {1'b0, 2'b00, 1'b0, 32'h55AA_55AA});

        // ---- 6: reset in WR_WAIT_B with two commands queued ----
        push(1'b1, 32'h80, 32'h8, 4'hF);
        wait_issue();
        tick();
        chk("t6_in_wait_b", bready, 1'b1);
        push(1'b0, 32'h84, 32'h0, 4'h0);
        push(1'b1, 32'h88, 32'h9, 4'hF);
        chk("t6_busy", busy, 1'b1);
        aresetn = 1'b0;
        #1;
        chk("t6_valids_off", {awvalid, wvalid, arvalid, bready, rready, resp_v}, 6'b0);
        chk("t6_busy_off", busy, 1'b0);
        chk("t6_error_clr", error, 1'b0);
        tick(); tick();
        aresetn = 1'b1;
        tick();
        chk("t6_ready", cmd_ready, 1'b1);
        tick(); tick(); tick(); tick();
        chk("t6_queue_empty", {awvalid, arvalid, busy}, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
